// File: rtl/paddle_pkg.sv
// Shared types and constants for the paddle position generator.
package paddle_pkg;

    // Digital ramp state of one channel.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SLOW = 2'd1,
        FAST = 2'd2
    } dig_state_t;

    // Signed joystick Y is flipped to offset binary with this constant.
    localparam logic [7:0] ANALOG_OFFSET = 8'h80;

    // Widest position the helpers are sized for.
    localparam int MAX_POS_W = 16;

    // Mid-screen position 2^(pos_w-1), returned in the widest supported width.
    function automatic logic [MAX_POS_W-1:0] MID_POS(input int pos_w);
        logic [MAX_POS_W-1:0] mid;
        mid = '0;
        mid[pos_w-1] = 1'b1;
        return mid;
    endfunction

endpackage

// File: rtl/paddle_channel.sv
// One paddle channel: analog IIR follower plus digital up/down ramp FSM.
module paddle_channel
    import paddle_pkg::*;
#(
    parameter int POS_W        = 8,
    parameter int ACCEL_TICKS  = 64,
    parameter int FAST_STEP    = 4,
    parameter int FILTER_SHIFT = 2
) (
    input  logic             clk_sys,
    input  logic             reset,
    input  logic             tick,
    input  logic [7:0]       y,
    input  logic             up,
    input  logic             down,
    input  logic             mode,
    input  logic             invert,
    output logic [POS_W-1:0] vpos,
    output logic             moving
);

    localparam int CNT_W = $clog2(ACCEL_TICKS + 1);
    localparam logic [MAX_POS_W-1:0] MID_FULL = MID_POS(POS_W);
    localparam logic [POS_W-1:0] MID = MID_FULL[POS_W-1:0];

    logic [POS_W-1:0] pos_reg, pos_next, pos_analog, pos_digital, target;
    logic [POS_W-1:0] vpos_reg;
    logic             moving_reg;
    dig_state_t       state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next, cnt_inc;
    logic             dir_up_reg, dir_up_next;
    logic             step_en, step_fast, dir_valid;
    logic [7:0]       t8;
    logic signed [POS_W:0] diff, shifted, step_a;
    logic [POS_W:0]   step_d, sum_d;

    // Analog target: offset-binary Y, widened by replicating its top bits.
    assign t8 = y ^ ANALOG_OFFSET;
    generate
        if (POS_W > 8) begin : g_wide
            assign target = {t8, t8[7 -: POS_W-8]};
        end else begin : g_narrow
            assign target = t8;
        end
    endgenerate

    // Analog step: shifted error, never smaller than one count while off target.
    always_comb begin
        diff    = $signed({1'b0, target}) - $signed({1'b0, pos_reg});
        shifted = diff >>> FILTER_SHIFT;
        step_a  = shifted;
        if (diff != '0 && shifted == '0) begin
            step_a = diff[POS_W] ? {(POS_W+1){1'b1}} : (POS_W+1)'(1);
        end
        pos_analog = pos_reg + step_a[POS_W-1:0];
    end

    // Ramp FSM next state: exactly one button pressed gives a direction.
    always_comb begin
        state_next  = state_reg;
        cnt_next    = cnt_reg;
        dir_up_next = dir_up_reg;
        step_en     = 1'b0;
        step_fast   = 1'b0;
        dir_valid   = up ^ down;
        cnt_inc     = cnt_reg + CNT_W'(1);
        case (state_reg)
            IDLE: begin
                if (dir_valid) begin
                    step_en     = 1'b1;
                    state_next  = SLOW;
                    cnt_next    = CNT_W'(1);
                    dir_up_next = up;
                end
            end
            SLOW: begin
                if (!dir_valid) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end else if (up == dir_up_reg) begin
                    step_en  = 1'b1;
                    cnt_next = cnt_inc;
                    if (cnt_inc >= CNT_W'(ACCEL_TICKS)) begin
                        state_next = FAST;
                    end
                end else begin
                    step_en     = 1'b1;
                    cnt_next    = CNT_W'(1);
                    dir_up_next = up;
                end
            end
            FAST: begin
                if (!dir_valid) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end else if (up == dir_up_reg) begin
                    step_en   = 1'b1;
                    step_fast = 1'b1;
                end else begin
                    step_en     = 1'b1;
                    state_next  = SLOW;
                    cnt_next    = CNT_W'(1);
                    dir_up_next = up;
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    // Digital step with saturation at both rails; up moves toward 0.
    always_comb begin
        step_d      = step_fast ? (POS_W+1)'(FAST_STEP) : (POS_W+1)'(1);
        sum_d       = {1'b0, pos_reg} + step_d;
        pos_digital = pos_reg;
        if (up) begin
            pos_digital = ({1'b0, pos_reg} < step_d) ? '0 : pos_reg - step_d[POS_W-1:0];
        end else begin
            pos_digital = sum_d[POS_W] ? '1 : sum_d[POS_W-1:0];
        end
        if (!mode) begin
            pos_next = pos_analog;
        end else if (step_en) begin
            pos_next = pos_digital;
        end else begin
            pos_next = pos_reg;
        end
    end

    // Position, output mapping and movement flag advance only on tick.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            pos_reg    <= MID;
            vpos_reg   <= invert ? ~MID : MID;
            moving_reg <= 1'b0;
        end else if (tick) begin
            pos_reg    <= pos_next;
            vpos_reg   <= invert ? ~pos_next : pos_next;
            moving_reg <= (pos_next != pos_reg);
        end
    end

    // Ramp state register; analog mode holds the ramp parked in IDLE.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_reg  <= IDLE;
            cnt_reg    <= '0;
            dir_up_reg <= 1'b0;
        end else if (!mode) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
        end else if (tick) begin
            state_reg  <= state_next;
            cnt_reg    <= cnt_next;
            dir_up_reg <= dir_up_next;
        end
    end

    assign vpos   = vpos_reg;
    assign moving = moving_reg;

endmodule

// File: rtl/paddle_ctrl.sv
// N-player paddle position generator: shared update tick plus per-player channels.
module paddle_ctrl
    import paddle_pkg::*;
#(
    parameter int NUM_PLAYERS  = 2,
    parameter int POS_W        = 8,
    parameter int RATE_DIV     = 50000,
    parameter int ACCEL_TICKS  = 64,
    parameter int FAST_STEP    = 4,
    parameter int FILTER_SHIFT = 2
) (
    input  logic                         clk_sys,
    input  logic                         reset,
    input  logic [16*NUM_PLAYERS-1:0]    joystick_analog,
    input  logic [NUM_PLAYERS-1:0]       joy_up,
    input  logic [NUM_PLAYERS-1:0]       joy_down,
    input  logic [NUM_PLAYERS-1:0]       mode,
    input  logic [NUM_PLAYERS-1:0]       invert,
    output logic [POS_W*NUM_PLAYERS-1:0] paddle_vpos,
    output logic [NUM_PLAYERS-1:0]       moving
);

    localparam int PRE_W = $clog2(RATE_DIV);
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(RATE_DIV - 1);

    logic [PRE_W-1:0] pre_reg;
    logic             tick;

    // Prescaler: counts 0..RATE_DIV-1 and wraps.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            pre_reg <= '0;
        end else if (pre_reg == PRE_LAST) begin
            pre_reg <= '0;
        end else begin
            pre_reg <= pre_reg + PRE_W'(1);
        end
    end

    assign tick = !reset && (pre_reg == PRE_LAST);

    genvar gi;
    generate
        for (gi = 0; gi < NUM_PLAYERS; gi++) begin : g_ch
            // X axis is not used by a vertical paddle.
            logic [7:0] joy_x_unused;
            assign joy_x_unused = joystick_analog[16*gi +: 8];

            paddle_channel #(
                .POS_W       (POS_W),
                .ACCEL_TICKS (ACCEL_TICKS),
                .FAST_STEP   (FAST_STEP),
                .FILTER_SHIFT(FILTER_SHIFT)
            ) u_ch (
                .clk_sys(clk_sys),
                .reset  (reset),
                .tick   (tick),
                .y      (joystick_analog[16*gi+8 +: 8]),
                .up     (joy_up[gi]),
                .down   (joy_down[gi]),
                .mode   (mode[gi]),
                .invert (invert[gi]),
                .vpos   (paddle_vpos[POS_W*gi +: POS_W]),
                .moving (moving[gi])
            );
        end
    endgenerate

endmodule

// File: tb/tb_paddle_ctrl.sv
// Scoreboard bench: two DUTs (unfiltered and filtered) against a rule-level model.
module tb_paddle_ctrl;

    localparam int ACCEL = 8;
    localparam int FSTEP = 4;

    logic        clk_sys = 1'b0;
    logic        reset;
    logic [31:0] joystick_analog;
    logic [1:0]  joy_up, joy_down, mode, invert;
    logic [15:0] vpos_f0, vpos_f2;
    logic [1:0]  mov_f0, mov_f2;

    always #5 clk_sys = ~clk_sys;

    paddle_ctrl #(.NUM_PLAYERS(2), .POS_W(8), .RATE_DIV(4), .ACCEL_TICKS(ACCEL),
                  .FAST_STEP(FSTEP), .FILTER_SHIFT(0)) dut_f0 (
        .clk_sys(clk_sys), .reset(reset), .joystick_analog(joystick_analog),
        .joy_up(joy_up), .joy_down(joy_down), .mode(mode), .invert(invert),
        .paddle_vpos(vpos_f0), .moving(mov_f0));

    paddle_ctrl #(.NUM_PLAYERS(2), .POS_W(8), .RATE_DIV(4), .ACCEL_TICKS(ACCEL),
                  .FAST_STEP(FSTEP), .FILTER_SHIFT(2)) dut_f2 (
        .clk_sys(clk_sys), .reset(reset), .joystick_analog(joystick_analog),
        .joy_up(joy_up), .joy_down(joy_down), .mode(mode), .invert(invert),
        .paddle_vpos(vpos_f2), .moving(mov_f2));

    typedef struct packed {
        logic [15:0] v0;
        logic [1:0]  m0;
        logic [15:0] v1;
        logic [1:0]  m1;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    // Model state: [dut][channel]; run = consecutive ticks in the same direction.
    int m_pos[2][2];
    int m_run[2][2];
    int m_dir[2][2];
    bit m_mov[2][2];

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            if (errors <= 40)
                $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
        end
    endtask

    function automatic exp_t make_exp();
        exp_t e;
        int   v;
        e = '0;
        for (int c = 0; c < 2; c++) begin
            v = invert[c] ? 255 - m_pos[0][c] : m_pos[0][c];
            e.v0[8*c +: 8] = v[7:0];
            e.m0[c] = m_mov[0][c];
            v = invert[c] ? 255 - m_pos[1][c] : m_pos[1][c];
            e.v1[8*c +: 8] = v[7:0];
            e.m1[c] = m_mov[1][c];
        end
        return e;
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++)
            for (int c = 0; c < 2; c++) begin
                m_pos[d][c] = 128;
                m_run[d][c] = 0;
                m_dir[d][c] = 0;
                m_mov[d][c] = 1'b0;
            end
    endtask

    task automatic model_tick();
        int old, tgt, diff, s, dv, step, np, shift;
        for (int d = 0; d < 2; d++) begin
            shift = (d == 0) ? 0 : 2;
            for (int c = 0; c < 2; c++) begin
                old = m_pos[d][c];
                np  = old;
                if (!mode[c]) begin
                    m_run[d][c] = 0;
                    m_dir[d][c] = 0;
                    tgt  = int'(joystick_analog[16*c+8 +: 8] ^ 8'h80);
                    diff = tgt - old;
                    s    = diff >>> shift;
                    if (diff != 0 && s == 0) s = (diff > 0) ? 1 : -1;
                    np = old + s;
                end else begin
                    dv = (joy_up[c] ^ joy_down[c]) ? (joy_up[c] ? -1 : 1) : 0;
                    if (dv == 0) begin
                        m_run[d][c] = 0;
                        m_dir[d][c] = 0;
                    end else begin
                        m_run[d][c] = (dv == m_dir[d][c]) ? m_run[d][c] + 1 : 1;
                        m_dir[d][c] = dv;
                        step = (m_run[d][c] > ACCEL) ? FSTEP : 1;
                        np = old + dv * step;
                        if (np < 0) np = 0;
                        if (np > 255) np = 255;
                    end
                end
                m_pos[d][c] = np;
                m_mov[d][c] = (np != old);
            end
        end
    endtask

    // One tick period: inputs applied right after an update edge, held 4 cycles.
    task automatic apply(input logic [31:0] joy, input logic [1:0] up, input logic [1:0] dn,
                         input logic [1:0] md, input logic [1:0] inv);
        joystick_analog = joy;
        joy_up   = up;
        joy_down = dn;
        mode     = md;
        invert   = inv;
        model_tick();
        sb_q.push_back(make_exp());
        repeat (4) @(negedge clk_sys);
    endtask

    task automatic do_reset();
        model_reset();
        sb_q.push_back(make_exp());
        reset = 1'b1;
        repeat (3) @(negedge clk_sys);
        reset = 1'b0;
    endtask

    function automatic logic [31:0] yy(input logic [7:0] y0, input logic [7:0] y1);
        return {y1, 8'h00, y0, 8'h00};
    endfunction

    // Monitor: outputs change on reset entry and on every 4th edge after release.
    exp_t cur;
    bit   have_exp = 1'b0;
    bit   prev_rs  = 1'b0;
    bit   rs;
    int   k = 0;

    task automatic compare_all(input string tag);
        for (int c = 0; c < 2; c++) begin
            check($sformatf("%s_vpos_f0_ch%0d", tag, c), int'(vpos_f0[8*c +: 8]), int'(cur.v0[8*c +: 8]));
            check($sformatf("%s_mov_f0_ch%0d", tag, c), int'(mov_f0[c]), int'(cur.m0[c]));
            check($sformatf("%s_vpos_f2_ch%0d", tag, c), int'(vpos_f2[8*c +: 8]), int'(cur.v1[8*c +: 8]));
            check($sformatf("%s_mov_f2_ch%0d", tag, c), int'(mov_f2[c]), int'(cur.m1[c]));
        end
    endtask

    task automatic pop_compare(input string tag);
        if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sb_underflow actual=empty required=entry t=%0t", $time);
        end else begin
            cur = sb_q.pop_front();
            have_exp = 1'b1;
            compare_all(tag);
        end
    endtask

    initial begin
        forever begin
            @(posedge clk_sys);
            rs = reset;
            #1;
            if (rs) begin
                if (!prev_rs) pop_compare("rst");
                k = 0;
            end else begin
                k++;
                if (k % 4 == 0) pop_compare("tick");
            end
            prev_rs = rs;
            @(negedge clk_sys);
            if (have_exp) compare_all("hold");
        end
    end

    // Stimulus: directed scenarios, then randomized periods.
    logic [31:0] r_joy;
    logic [1:0]  r_up, r_dn, r_md, r_iv;

    initial begin
        joystick_analog = '0;
        joy_up   = '0;
        joy_down = '0;
        mode     = 2'b10;
        invert   = 2'b01;
        do_reset();

        apply(yy(8'h7F, 8'h00), 2'b00, 2'b00, 2'b10, 2'b00);
        apply(yy(8'h80, 8'h00), 2'b00, 2'b00, 2'b10, 2'b00);
        apply(yy(8'h00, 8'h00), 2'b00, 2'b00, 2'b10, 2'b00);
        for (int i = 0; i < 30; i++) apply(yy(8'h7F, 8'h00), 2'b00, 2'b00, 2'b10, 2'b00);

        do_reset();
        for (int i = 0; i < 12; i++) apply('0, 2'b00, 2'b01, 2'b11, 2'b00);
        for (int i = 0; i < 2; i++)  apply('0, 2'b00, 2'b00, 2'b11, 2'b00);
        for (int i = 0; i < 2; i++)  apply('0, 2'b01, 2'b01, 2'b11, 2'b00);
        for (int i = 0; i < 60; i++) apply('0, 2'b01, 2'b00, 2'b11, 2'b00);
        for (int i = 0; i < 3; i++)  apply('0, 2'b00, 2'b01, 2'b11, 2'b00);

        for (int i = 0; i < 10; i++) apply('0, 2'b00, 2'b01, 2'b11, 2'b00);
        do_reset();
        apply('0, 2'b00, 2'b01, 2'b11, 2'b00);
        for (int i = 0; i < 18; i++) apply('0, 2'b01, 2'b00, 2'b11, 2'b00);
        for (int i = 0; i < 2; i++)  apply(yy(8'h00, 8'h00), 2'b00, 2'b00, 2'b10, 2'b00);

        r_joy = '0; r_up = '0; r_dn = '0; r_md = 2'b11; r_iv = '0;
        for (int i = 0; i < 400; i++) begin
            for (int c = 0; c < 2; c++) begin
                if ($urandom_range(7) == 0) r_md[c] = 1'($urandom_range(1));
                if ($urandom_range(7) == 0) {r_up[c], r_dn[c]} = 2'($urandom_range(3));
                if ($urandom_range(3) == 0) r_joy[16*c+8 +: 8] = 8'($urandom);
                r_joy[16*c +: 8] = 8'($urandom);
                if ($urandom_range(15) == 0) r_iv[c] = ~r_iv[c];
            end
            if ($urandom_range(49) == 0) do_reset();
            apply(r_joy, r_up, r_dn, r_md, r_iv);
        end

        repeat (2) @(negedge clk_sys);
        check("sb_drain", sb_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog actual=running required=finished t=%0t", $time);
        $fatal(1, "timeout");
    end

endmodule
